// File: rtl/meta_array_pkg.sv
// -----------------------------------------------------------------------------
// meta_array_pkg
// Shared geometry, state encoding and field helper for the banked metadata
// array controller (128 sets x 8 ways x 2-bit fields).
// -----------------------------------------------------------------------------
package meta_array_pkg;

    localparam int unsigned SETS   = 128;
    localparam int unsigned WAYS   = 8;
    localparam int unsigned DW     = 2;
    localparam int unsigned ADDR_W = $clog2(SETS);
    localparam int unsigned ROW_W  = WAYS * DW;

    localparam logic [DW-1:0] INIT_VAL = '0;

    // Controller phase: clearing sweep, then normal service.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Extract the field of way w from a packed array row.
    function automatic logic [DW-1:0] way_field(input logic [ROW_W-1:0] row,
                                                input int unsigned     w);
        return row[w*DW +: DW];
    endfunction

endpackage : meta_array_pkg

// File: rtl/meta_array_ctrl.sv
// -----------------------------------------------------------------------------
// meta_array_ctrl
// Front-end controller for the 2-port banked metadata array. After reset it
// sweeps INIT_VAL into every set, then serves one lookup and one per-way
// update per cycle. Lookups return one cycle later; a lookup that hits the set
// being updated in the same cycle sees the new value (the array itself is
// read-old on collisions).
//
// Ports
//   clock, reset            sole clock (rising edge), synchronous active-high reset
//   init_done               high once the clearing sweep has completed
//   rd_valid/rd_ready/rd_set            lookup request channel
//   resp_valid/resp_data                one-cycle lookup response pulse
//   upd_valid/upd_ready/upd_set/
//   upd_mask/upd_data                   per-way update request (one-hot mask)
//   arr_r_addr / arr_r_data             array read port (data one cycle later)
//   arr_w_en/arr_w_addr/
//   arr_w_maskOH/arr_w_data             array write port (data broadcast to mask)
// -----------------------------------------------------------------------------
module meta_array_ctrl #(
    parameter int unsigned    SETS     = meta_array_pkg::SETS,
    parameter int unsigned    WAYS     = meta_array_pkg::WAYS,
    parameter int unsigned    DW       = meta_array_pkg::DW,
    parameter logic [DW-1:0]  INIT_VAL = DW'(meta_array_pkg::INIT_VAL),
    localparam int unsigned   ADDR_W   = (SETS > 1) ? $clog2(SETS) : 1
) (
    input  logic                 clock,
    input  logic                 reset,

    output logic                 init_done,

    input  logic                 rd_valid,
    output logic                 rd_ready,
    input  logic [ADDR_W-1:0]    rd_set,
    output logic                 resp_valid,
    output logic [WAYS*DW-1:0]   resp_data,

    input  logic                 upd_valid,
    output logic                 upd_ready,
    input  logic [ADDR_W-1:0]    upd_set,
    input  logic [WAYS-1:0]      upd_mask,
    input  logic [DW-1:0]        upd_data,

    output logic [ADDR_W-1:0]    arr_r_addr,
    input  logic [WAYS*DW-1:0]   arr_r_data,
    output logic                 arr_w_en,
    output logic [ADDR_W-1:0]    arr_w_addr,
    output logic [WAYS-1:0]      arr_w_maskOH,
    output logic [DW-1:0]        arr_w_data
);

    import meta_array_pkg::*;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;

    logic                resp_valid_q;
    logic [WAYS-1:0]     fwd_mask_q, fwd_mask_d;
    logic [DW-1:0]       fwd_data_q, fwd_data_d;

    logic                rd_fire;
    logic                upd_fire;
    logic                collide;

    // Handshake qualification: nothing is accepted until the sweep is done.
    assign init_done = (state_q == ST_RUN);
    assign rd_ready  = init_done;
    assign upd_ready = init_done;
    assign rd_fire   = rd_valid  && init_done;
    assign upd_fire  = upd_valid && init_done;

    // Same-cycle lookup/update to one set: the array would return old data.
    assign collide   = rd_fire && upd_fire && (upd_set == rd_set);

    assign arr_r_addr = rd_set;

    // State and sweep counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, sweep counter and array write port.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        arr_w_en     = 1'b0;
        arr_w_addr   = '0;
        arr_w_maskOH = '0;
        arr_w_data   = '0;

        if (state_q == ST_INIT) begin
            arr_w_en     = 1'b1;
            arr_w_addr   = cnt_q;
            arr_w_maskOH = '1;
            arr_w_data   = INIT_VAL;
            cnt_d        = cnt_q + ADDR_W'(1);
            if (cnt_q == ADDR_W'(SETS - 1)) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end else begin
            // A zero mask is a legal no-op and must not pulse the write enable.
            arr_w_en     = upd_fire && (upd_mask != '0);
            arr_w_addr   = upd_set;
            arr_w_maskOH = upd_mask;
            arr_w_data   = upd_data;
        end
    end

    // Forwarding capture: only a colliding update contributes a mask.
    always_comb begin
        fwd_mask_d = '0;
        fwd_data_d = upd_data;
        if (collide) begin
            fwd_mask_d = upd_mask;
        end
    end

    // Response valid and forwarding registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            fwd_mask_q   <= '0;
            fwd_data_q   <= '0;
        end else begin
            resp_valid_q <= rd_fire;
            fwd_mask_q   <= fwd_mask_d;
            fwd_data_q   <= fwd_data_d;
        end
    end

    // A reset arriving in the response cycle cancels the pending response.
    assign resp_valid = resp_valid_q && !reset;

    // Forwarding mux: masked ways take the captured update value.
    always_comb begin
        resp_data = '0;
        if (resp_valid) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                resp_data[w*DW +: DW] = fwd_mask_q[w] ? fwd_data_q
                                                      : arr_r_data[w*DW +: DW];
            end
        end
    end

endmodule : meta_array_ctrl

// File: tb/tb_meta_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_meta_array_ctrl
// Self-checking bench for meta_array_ctrl. A behavioural read-old array sits on
// the array ports; a separate reference image of the array contents produces
// expected lookup results, which are queued when a lookup is driven and popped
// when the response appears.
// -----------------------------------------------------------------------------
module tb_meta_array_ctrl;

    import meta_array_pkg::*;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 init_done;
    logic                 rd_valid = 1'b0;
    logic                 rd_ready;
    logic [ADDR_W-1:0]    rd_set = '0;
    logic                 resp_valid;
    logic [ROW_W-1:0]     resp_data;
    logic                 upd_valid = 1'b0;
    logic                 upd_ready;
    logic [ADDR_W-1:0]    upd_set = '0;
    logic [WAYS-1:0]      upd_mask = '0;
    logic [DW-1:0]        upd_data = '0;
    logic [ADDR_W-1:0]    arr_r_addr;
    logic [ROW_W-1:0]     arr_r_data = '0;
    logic                 arr_w_en;
    logic [ADDR_W-1:0]    arr_w_addr;
    logic [WAYS-1:0]      arr_w_maskOH;
    logic [DW-1:0]        arr_w_data;

    int                   checks   = 0;
    int                   failures = 0;

    logic [ROW_W-1:0]     mem     [SETS];   // array contents (behavioural array)
    logic [ROW_W-1:0]     exp_mem [SETS];   // reference image of what the array should hold
    logic [ROW_W-1:0]     exp_q   [$];      // expected lookup responses
    bit                   pend_rv = 1'b0;   // a lookup was driven in the previous cycle

    always #5 clock = ~clock;

    meta_array_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .init_done    (init_done),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_set       (rd_set),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_set      (upd_set),
        .upd_mask     (upd_mask),
        .upd_data     (upd_data),
        .arr_r_addr   (arr_r_addr),
        .arr_r_data   (arr_r_data),
        .arr_w_en     (arr_w_en),
        .arr_w_addr   (arr_w_addr),
        .arr_w_maskOH (arr_w_maskOH),
        .arr_w_data   (arr_w_data)
    );

    // Read-old array: registered read, masked broadcast write.
    always @(posedge clock) begin
        arr_r_data <= mem[arr_r_addr];
        if (arr_w_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (arr_w_maskOH[w]) mem[arr_w_addr][w*DW +: DW] <= arr_w_data;
            end
        end
    end

    // Accepted update masks must be one-hot or zero.
    always @(posedge clock) begin
        if (!reset && upd_valid && upd_ready) begin
            assert ($onehot0(upd_mask)) else $error("illegal upd_mask %h", upd_mask);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one RUN-phase cycle and update the reference image / queue.
    task automatic drive(input bit rv, input logic [ADDR_W-1:0] rs,
                         input bit uv, input logic [ADDR_W-1:0] us,
                         input logic [WAYS-1:0] um, input logic [DW-1:0] ud);
        logic [ROW_W-1:0] row;
        rd_valid  = rv;
        rd_set    = rs;
        upd_valid = uv;
        upd_set   = us;
        upd_mask  = um;
        upd_data  = ud;
        if (rv) begin
            row = exp_mem[rs];
            if (uv && us == rs) begin
                for (int w = 0; w < WAYS; w++) if (um[w]) row[w*DW +: DW] = ud;
            end
            exp_q.push_back(row);
        end
        if (uv) begin
            for (int w = 0; w < WAYS; w++) if (um[w]) exp_mem[us][w*DW +: DW] = ud;
        end
        pend_rv = rv;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL rst_init_done: got %b expected 0", init_done); end
        checks++; if (rd_ready !== 1'b0) begin failures++; $display("FAIL rst_rd_ready: got %b expected 0", rd_ready); end
        checks++; if (upd_ready !== 1'b0) begin failures++; $display("FAIL rst_upd_ready: got %b expected 0", upd_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_data !== 16'h0000) begin failures++; $display("FAIL rst_resp_data: got %h expected 0000", resp_data); end
        checks++; if (arr_w_en !== 1'b1) begin failures++; $display("FAIL rst_arr_w_en: got %b expected 1", arr_w_en); end
        checks++; if (arr_w_addr !== 7'd0) begin failures++; $display("FAIL rst_arr_w_addr: got %0d expected 0", arr_w_addr); end
        checks++; if (arr_w_maskOH !== 8'hFF) begin failures++; $display("FAIL rst_arr_w_mask: got %h expected ff", arr_w_maskOH); end
    endtask

    // Sweep: addresses 0..SETS-1 on consecutive cycles, requests ignored meanwhile.
    task automatic test_sweep();
        reset = 1'b0;
        for (int c = 0; c < SETS; c++) begin
            checks++;
            if (arr_w_en !== 1'b1 || arr_w_addr !== ADDR_W'(c) || arr_w_maskOH !== 8'hFF ||
                arr_w_data !== 2'b00 || rd_ready !== 1'b0 || upd_ready !== 1'b0 ||
                init_done !== 1'b0 || resp_valid !== 1'b0) begin
                failures++;
                $display("FAIL sweep_cycle_%0d: got en=%b addr=%0d mask=%h data=%b rdy=%b/%b done=%b rv=%b expected en=1 addr=%0d mask=ff data=00 rdy=0/0 done=0 rv=0",
                         c, arr_w_en, arr_w_addr, arr_w_maskOH, arr_w_data, rd_ready, upd_ready, init_done, resp_valid, c);
            end
            if (c < SETS - 2) begin
                rd_valid  = 1'($urandom_range(0, 1));
                rd_set    = ADDR_W'($urandom_range(0, SETS - 1));
                upd_valid = 1'($urandom_range(0, 1));
                upd_set   = ADDR_W'($urandom_range(0, SETS - 1));
                upd_mask  = WAYS'(1) << $urandom_range(0, WAYS - 1);
                upd_data  = DW'($urandom_range(1, 3));
            end else begin
                rd_valid  = 1'b0;
                upd_valid = 1'b0;
            end
            tick();
        end
        checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL sweep_done_at_%0d: got %b expected 1", SETS, init_done); end
        checks++; if (rd_ready !== 1'b1 || upd_ready !== 1'b1) begin failures++; $display("FAIL run_ready: got %b/%b expected 1/1", rd_ready, upd_ready); end
        checks++; if (arr_w_en !== 1'b0) begin failures++; $display("FAIL run_idle_w_en: got %b expected 0", arr_w_en); end
        for (int s = 0; s < SETS; s++) exp_mem[s] = '0;
    endtask

    task automatic test_basic();
        logic [ROW_W-1:0] e;
        drive(1'b0, 7'd0, 1'b1, 7'd5, 8'h04, 2'b11);
        #1;
        checks++;
        if (arr_w_en !== 1'b1 || arr_w_addr !== 7'd5 || arr_w_maskOH !== 8'h04 || arr_w_data !== 2'b11) begin
            failures++;
            $display("FAIL basic_write_port: got en=%b addr=%0d mask=%h data=%b expected en=1 addr=5 mask=04 data=11",
                     arr_w_en, arr_w_addr, arr_w_maskOH, arr_w_data);
        end
        tick();
        drive(1'b1, 7'd5, 1'b0, 7'd0, 8'h00, 2'b00);
        #1;
        checks++; if (arr_r_addr !== 7'd5) begin failures++; $display("FAIL basic_r_addr: got %0d expected 5", arr_r_addr); end
        tick();
        checks++; if (resp_valid !== pend_rv) begin failures++; $display("FAIL basic_resp_valid: got %b expected %b", resp_valid, pend_rv); end
        if (resp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL basic_unexpected_resp: got %h expected none", resp_data); end
            else begin
                e = exp_q.pop_front();
                if (resp_data !== e) begin failures++; $display("FAIL basic_resp_data: got %h expected %h", resp_data, e); end
            end
        end
        checks++; if (resp_data !== 16'h0030) begin failures++; $display("FAIL basic_literal: got %h expected 0030", resp_data); end
        drive(1'b0, 7'd0, 1'b0, 7'd0, 8'h00, 2'b00);
    endtask

    task automatic test_collision();
        logic [ROW_W-1:0] e;
        logic [DW-1:0]    way7;
        drive(1'b0, 7'd0, 1'b1, 7'd9, 8'h80, 2'b01);   // array now holds 01 in way 7
        tick();
        drive(1'b1, 7'd9, 1'b1, 7'd9, 8'h80, 2'b10);
        tick();
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL coll_resp_valid: got %b expected 1", resp_valid); end
        if (resp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL coll_unexpected_resp: got %h expected none", resp_data); end
            else begin
                e = exp_q.pop_front();
                if (resp_data !== e) begin failures++; $display("FAIL coll_resp_data: got %h expected %h", resp_data, e); end
            end
        end
        way7 = way_field(resp_data, 7);
        checks++; if (way7 !== 2'b10) begin failures++; $display("FAIL coll_way7: got %b expected 10", way7); end
        drive(1'b0, 7'd0, 1'b0, 7'd0, 8'h00, 2'b00);
    endtask

    task automatic test_diff_set();
        logic [ROW_W-1:0] e;
        drive(1'b0, 7'd0, 1'b1, 7'd4, 8'h02, 2'b01);
        tick();
        drive(1'b1, 7'd4, 1'b1, 7'd3, 8'h02, 2'b10);
        #1;
        checks++; if (arr_w_en !== 1'b1 || arr_w_addr !== 7'd3) begin failures++; $display("FAIL diff_write_port: got en=%b addr=%0d expected en=1 addr=3", arr_w_en, arr_w_addr); end
        tick();
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL diff_resp_valid: got %b expected 1", resp_valid); end
        if (resp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("FAIL diff_unexpected_resp: got %h expected none", resp_data); end
            else begin
                e = exp_q.pop_front();
                if (resp_data !== e) begin failures++; $display("FAIL diff_resp_data: got %h expected %h", resp_data, e); end
            end
        end
        checks++; if (resp_data !== 16'h0004) begin failures++; $display("FAIL diff_literal: got %h expected 0004", resp_data); end
        drive(1'b0, 7'd0, 1'b0, 7'd0, 8'h00, 2'b00);
    endtask

    // Lookups of sets 0,1,2 on consecutive cycles with zero-mask updates alongside.
    task automatic test_back_to_back();
        logic [ROW_W-1:0] e;
        drive(1'b0, 7'd0, 1'b1, 7'd1, 8'h01, 2'b11);
        tick();
        drive(1'b0, 7'd0, 1'b1, 7'd2, 8'h40, 2'b01);
        tick();
        drive(1'b0, 7'd0, 1'b1, 7'd0, 8'h08, 2'b10);
        tick();
        pend_rv = 1'b0;
        for (int i = 0; i <= 3; i++) begin
            if (i > 0) begin
                checks++; if (resp_valid !== pend_rv) begin failures++; $display("FAIL b2b_resp_valid_%0d: got %b expected %b", i, resp_valid, pend_rv); end
                if (resp_valid) begin
                    checks++;
                    if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_unexpected_resp_%0d: got %h expected none", i, resp_data); end
                    else begin
                        e = exp_q.pop_front();
                        if (resp_data !== e) begin failures++; $display("FAIL b2b_resp_data_%0d: got %h expected %h", i, resp_data, e); end
                    end
                end
            end
            if (i < 3) begin
                drive(1'b1, ADDR_W'(i), 1'b1, ADDR_W'(i), 8'h00, 2'b11);
                #1;
                checks++; if (arr_w_en !== 1'b0) begin failures++; $display("FAIL b2b_zero_mask_w_en_%0d: got %b expected 0", i, arr_w_en); end
            end else begin
                drive(1'b0, 7'd0, 1'b0, 7'd0, 8'h00, 2'b00);
            end
            tick();
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_queue_drain: got %0d expected 0", exp_q.size()); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_no_extra_resp: got %b expected 0", resp_valid); end
    endtask

    // Reset right after a lookup, then a reset in the middle of the new sweep.
    task automatic test_midsweep_reset();
        int n;
        rd_valid = 1'b1;
        rd_set   = 7'd5;
        tick();
        rd_valid = 1'b0;
        reset    = 1'b1;
        #1;
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_suppress_resp: got %b expected 0", resp_valid); end
        tick();
        reset = 1'b0;
        repeat (60) tick();
        checks++; if (arr_w_addr !== 7'd60 || arr_w_en !== 1'b1) begin failures++; $display("FAIL mid_sweep_addr60: got en=%b addr=%0d expected en=1 addr=60", arr_w_en, arr_w_addr); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (arr_w_addr !== 7'd0 || init_done !== 1'b0) begin failures++; $display("FAIL mid_sweep_restart: got addr=%0d done=%b expected addr=0 done=0", arr_w_addr, init_done); end
        n = 0;
        while (init_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++; if (n != SETS) begin failures++; $display("FAIL mid_sweep_done_latency: got %0d expected %0d", n, SETS); end
        for (int s = 0; s < SETS; s++) exp_mem[s] = '0;
        exp_q.delete();
    endtask

    // After the re-sweep, previously written sets read back as cleared.
    task automatic test_post_sweep_lookup();
        logic [ROW_W-1:0] e;
        drive(1'b1, 7'd5, 1'b0, 7'd0, 8'h00, 2'b00);
        tick();
        drive(1'b1, 7'd9, 1'b0, 7'd0, 8'h00, 2'b00);
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL post_resp_valid_a: got %b expected 1", resp_valid); end
        if (resp_valid && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++; if (resp_data !== e) begin failures++; $display("FAIL post_resp_data_a: got %h expected %h", resp_data, e); end
        end
        tick();
        drive(1'b0, 7'd0, 1'b0, 7'd0, 8'h00, 2'b00);
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL post_resp_valid_b: got %b expected 1", resp_valid); end
        if (resp_valid && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++; if (resp_data !== e) begin failures++; $display("FAIL post_resp_data_b: got %h expected %h", resp_data, e); end
        end
        tick();
    endtask

    initial begin
        for (int s = 0; s < SETS; s++) begin
            mem[s]     = ROW_W'($urandom);
            exp_mem[s] = '0;
        end
        test_reset();
        test_sweep();
        test_basic();
        test_collision();
        test_diff_set();
        test_back_to_back();
        test_midsweep_reset();
        test_post_sweep_lookup();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_meta_array_ctrl
